// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// consecutive words leave on the serial line with no idle bits between them.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  // Handshake: a word transfers on any rising edge where in_valid and
  // in_ready are both high; in_data is ignored on every other edge.
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == LAST);
  assign shifted  = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg  <= in_data;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            sreg <= shifted;
            cnt  <= cnt + CW'(1);
            if (accept) begin
              hold      <= in_data;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            sreg      <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (accept) begin
            // A word arriving on the last bit goes straight into sreg.
            sreg <= in_data;
            cnt  <= '0;
          end else begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = !hold_full && !reset;
  assign out_valid   = (state == S_SHIFT);
  assign out         = out_valid ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : IDLE_BIT;
  assign frame_start = out_valid && (cnt == '0);
  assign busy        = out_valid || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: table of per-cycle vectors, hand sequences for
// LSB-first, idle level and mid-word reset, plus a per-instance bit scoreboard.
module tb_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: WIDTH=4 MSB first, u1: WIDTH=4 LSB first, u2: WIDTH=8 idle high
  logic       rst0, v0, rdy0, out0, ov0, fs0, busy0;
  logic [3:0] d0;
  logic       rst1, v1, rdy1, out1, ov1, fs1, busy1;
  logic [3:0] d1;
  logic       rst2, v2, rdy2, out2, ov2, fs2, busy2;
  logic [7:0] d2;

  bit_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .reset(rst0), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
    .out(out0), .out_valid(ov0), .frame_start(fs0), .busy(busy0));
  bit_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .reset(rst1), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .out(out1), .out_valid(ov1), .frame_start(fs1), .busy(busy1));
  bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u2 (
    .clk(clk), .reset(rst2), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
    .out(out2), .out_valid(ov2), .frame_start(fs2), .busy(busy2));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: expected serial bits pushed on each accepting edge, popped
  // whenever out_valid is seen; a reset edge discards anything pending.
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  logic [0:0] exp_q2[$];

  always @(posedge clk) begin
    if (rst0) exp_q0.delete();
    else if (v0 && rdy0) for (int i = 3; i >= 0; i--) exp_q0.push_back(d0[i]);
    if (rst1) exp_q1.delete();
    else if (v1 && rdy1) for (int i = 0; i < 4; i++) exp_q1.push_back(d1[i]);
    if (rst2) exp_q2.delete();
    else if (v2 && rdy2) for (int i = 7; i >= 0; i--) exp_q2.push_back(d2[i]);
  end

  always @(negedge clk) begin
    if (ov0 === 1'b1) begin
      if (exp_q0.size() == 0) check("sb0_unexpected_bit", 32'(ov0), 32'd0);
      else check("sb0_bit", 32'(out0), 32'(exp_q0.pop_front()));
    end
    if (ov1 === 1'b1) begin
      if (exp_q1.size() == 0) check("sb1_unexpected_bit", 32'(ov1), 32'd0);
      else check("sb1_bit", 32'(out1), 32'(exp_q1.pop_front()));
    end
    if (ov2 === 1'b1) begin
      if (exp_q2.size() == 0) check("sb2_unexpected_bit", 32'(ov2), 32'd0);
      else check("sb2_bit", 32'(out2), 32'(exp_q2.pop_front()));
    end
  end

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       o;
    logic       ov;
    logic       fs;
    logic       rdy;
    logic       bsy;
  } vec_t;

  vec_t tbl[26];

  initial begin
    logic [7:0] w2;
    logic [3:0] lsb_word;
    int t;

    // Row j: outputs expected in cycle j, inputs offered in cycle j.
    // Single word 4'hB
    tbl[0]  = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // Back-to-back 4'hB then 4'h5 through the holding register
    tbl[6]  = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // Bypass: 4'h9 offered only during the last bit of 4'hB
    tbl[16] = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[24] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[25] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready0", 32'(rdy0), 32'd0);
    check("rst_out_valid0", 32'(ov0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_frame_start0", 32'(fs0), 32'd0);
    check("rst_out0", 32'(out0), 32'd0);
    check("rst_out2_idle", 32'(out2), 32'd1);
    check("rst_in_ready2", 32'(rdy2), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    check("post_rst_in_ready0", 32'(rdy0), 32'd1);

    for (int j = 0; j < 26; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out", j), 32'(out0), 32'(tbl[j].o));
      check($sformatf("tbl%0d_out_valid", j), 32'(ov0), 32'(tbl[j].ov));
      check($sformatf("tbl%0d_frame_start", j), 32'(fs0), 32'(tbl[j].fs));
      check($sformatf("tbl%0d_in_ready", j), 32'(rdy0), 32'(tbl[j].rdy));
      check($sformatf("tbl%0d_busy", j), 32'(busy0), 32'(tbl[j].bsy));
      v0 = tbl[j].v;
      d0 = tbl[j].d;
    end

    // LSB-first: 4'b1101 leaves as 1,0,1,1
    lsb_word = 4'b1011;
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 4'b1101;
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lsb_out%0d", i), 32'(out1), 32'(lsb_word[3-i]));
      check($sformatf("lsb_valid%0d", i), 32'(ov1), 32'd1);
      check($sformatf("lsb_fs%0d", i), 32'(fs1), (i == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    check("lsb_idle_valid", 32'(ov1), 32'd0);

    // Random streaming on both 4-bit instances
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      v0 = ($urandom_range(0, 3) != 0);
      d0 = 4'($urandom_range(0, 15));
      v1 = ($urandom_range(0, 2) != 0);
      d1 = 4'($urandom_range(0, 15));
    end
    v0 = 1'b0; v1 = 1'b0;
    t = 0;
    while ((busy0 || busy1) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 32'(busy0 | busy1), 32'd0);

    // Idle level with IDLE_BIT=1
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle2_out%0d", i), 32'(out2), 32'd1);
      check($sformatf("idle2_valid%0d", i), 32'(ov2), 32'd0);
    end

    // Reset in the middle of 8'hA5 with a word offered during reset
    v2 = 1'b1; d2 = 8'hA5;
    @(posedge clk); #1;
    v2 = 1'b0; d2 = 8'hFF;
    check("mid_first_bit", 32'(out2), 32'd1);
    check("mid_first_fs", 32'(fs2), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b1; v2 = 1'b1; d2 = 8'h3C;
    #1;
    check("mid_rst_in_ready", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    check("mid_after_rst_valid", 32'(ov2), 32'd0);
    check("mid_after_rst_busy", 32'(busy2), 32'd0);
    check("mid_after_rst_out", 32'(out2), 32'd1);
    check("mid_after_rst_fs", 32'(fs2), 32'd0);
    rst2 = 1'b0; v2 = 1'b0;
    #1;
    check("mid_after_rst_in_ready", 32'(rdy2), 32'd1);
    @(posedge clk); #1;
    check("mid_still_idle", 32'(ov2), 32'd0);
    w2 = 8'hC3;
    v2 = 1'b1; d2 = w2;
    @(posedge clk); #1;
    v2 = 1'b0; d2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("post_rst_bit%0d", i), 32'(out2), 32'(w2[7-i]));
      check($sformatf("post_rst_fs%0d", i), 32'(fs2), (i == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    check("post_rst_idle_valid", 32'(ov2), 32'd0);
    check("post_rst_idle_out", 32'(out2), 32'd1);

    @(posedge clk); #1;
    check("sb0_leftover", 32'(exp_q0.size()), 32'd0);
    check("sb1_leftover", 32'(exp_q1.size()), 32'd0);
    check("sb2_leftover", 32'(exp_q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
